// File: rtl/ps2_mouse_pkg.sv
// Shared types and PS/2 protocol constants for the mouse sequencer.
`timescale 1ns/1ps
package ps2_mouse_pkg;

   typedef enum logic [3:0] {
      ST_SEND_FF,
      ST_WAIT_ACK,
      ST_WAIT_BAT,
      ST_WAIT_ID,
      ST_SEND_F4,
      ST_WAIT_ACK2,
      ST_STREAM_B0,
      ST_STREAM_B1,
      ST_STREAM_B2,
      ST_APPLY,
      ST_ERROR
   } mouse_state_t;

   // First byte of a stream packet, MSB first.
   typedef struct packed {
      logic yovf;
      logic xovf;
      logic ysign;
      logic xsign;
      logic always1;
      logic mid;
      logic right;
      logic left;
   } mouse_status_t;

   localparam logic [7:0] CMD_RESET  = 8'hFF;
   localparam logic [7:0] CMD_ENABLE = 8'hF4;
   localparam logic [7:0] RSP_ACK    = 8'hFA;
   localparam logic [7:0] RSP_RESEND = 8'hFE;
   localparam logic [7:0] RSP_BAT_OK = 8'hAA;
   localparam logic [7:0] RSP_ID_STD = 8'h00;

endpackage

// File: rtl/ps2_mouse_ctrl_cursor.sv
// Cursor accumulator: applies one packet's signed deltas and clamps to the screen.
`timescale 1ns/1ps
module mouse_cursor_accum
   import ps2_mouse_pkg::*;
#(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_apply,
   input  mouse_status_t i_status,
   input  logic [7:0]    i_dx,
   input  logic [7:0]    i_dy,
   output logic [9:0]    o_x,
   output logic [9:0]    o_y,
   output logic [2:0]    o_buttons,
   output logic          o_pkt_valid
);

   localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - 1);
   localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - 1);

   function automatic logic [9:0] clamp_coord(input logic signed [11:0] v,
                                               input logic signed [11:0] vmax);
      if (v < 12'sd0)
         return 10'd0;
      if (v > vmax)
         return vmax[9:0];
      return v[9:0];
   endfunction

   logic [9:0]         r_x, r_y;
   logic [2:0]         r_buttons;
   logic               r_pkt_valid;
   logic signed [11:0] w_dx, w_dy, w_x_next, w_y_next;
   logic               w_take;

   // An overflowed axis carries a meaningless magnitude, so it contributes nothing.
   assign w_dx     = i_status.xovf ? 12'sd0 : {{4{i_status.xsign}}, i_dx};
   assign w_dy     = i_status.yovf ? 12'sd0 : {{4{i_status.ysign}}, i_dy};
   assign w_x_next = $signed({2'b00, r_x}) + w_dx;
   assign w_y_next = $signed({2'b00, r_y}) - w_dy;
   // The sync check guarantees always1; a status without it is never applied.
   assign w_take   = i_apply && i_status.always1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x         <= 10'(SCREEN_W / 2);
         r_y         <= 10'(SCREEN_H / 2);
         r_buttons   <= 3'b000;
         r_pkt_valid <= 1'b0;
      end else begin
         r_pkt_valid <= w_take;
         if (w_take) begin
            r_x       <= clamp_coord(w_x_next, X_MAX);
            r_y       <= clamp_coord(w_y_next, Y_MAX);
            r_buttons <= {i_status.mid, i_status.right, i_status.left};
         end
      end
   end

   assign o_x         = r_x;
   assign o_y         = r_y;
   assign o_buttons   = r_buttons;
   assign o_pkt_valid = r_pkt_valid;

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse sequencer: reset/enable init with timeouts and retry, then 3-byte packet decode.
`timescale 1ns/1ps
module ps2_mouse_ctrl
   import ps2_mouse_pkg::*;
#(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int TIMEOUT_CYC = 2_500_000,
   parameter int MAX_RETRY   = 3,
   parameter int SKIP_INIT   = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx_done_tick,
   input  logic [7:0] i_rx_data,
   input  logic       i_tx_idle,
   input  logic       i_tx_done_tick,
   output logic       o_wr_ps2,
   output logic [7:0] o_tx_data,
   output logic [9:0] o_mouse_x,
   output logic [9:0] o_mouse_y,
   output logic [2:0] o_buttons,
   output logic       o_pkt_valid,
   output logic       o_init_done,
   output logic       o_err
);

   localparam int                 CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam int                 RTY_W    = $clog2(MAX_RETRY + 1);
   localparam logic [RTY_W-1:0]   RTY_LAST = RTY_W'(MAX_RETRY - 1);
   localparam mouse_state_t       ST_RST   = (SKIP_INIT != 0) ? ST_STREAM_B0 : ST_SEND_FF;

   mouse_state_t     r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [RTY_W-1:0] r_retry;
   logic             r_sent, r_wr, r_init_done, r_err;
   logic [7:0]       r_tx_data, r_dx, r_dy;
   mouse_status_t    r_status;

   logic             w_rx, w_timeout, w_is_wait;
   logic [7:0]       w_expect;
   mouse_state_t     w_ok_next, w_fail_tgt;

   // A byte arriving together with tx_done_tick is lost.
   assign w_rx      = i_rx_done_tick && !i_tx_done_tick;
   assign w_timeout = (r_cnt == CNT_LAST);

   always_comb begin
      w_is_wait = 1'b1;
      w_expect  = RSP_ACK;
      w_ok_next = ST_WAIT_BAT;
      case (r_state)
         ST_WAIT_ACK:  begin w_expect = RSP_ACK;    w_ok_next = ST_WAIT_BAT;  end
         ST_WAIT_BAT:  begin w_expect = RSP_BAT_OK; w_ok_next = ST_WAIT_ID;   end
         ST_WAIT_ID:   begin w_expect = RSP_ID_STD; w_ok_next = ST_SEND_F4;   end
         ST_WAIT_ACK2: begin w_expect = RSP_ACK;    w_ok_next = ST_STREAM_B0; end
         default:      w_is_wait = 1'b0;
      endcase
   end

   // A resend request after F4 repeats F4; every other failure restarts from FF.
   assign w_fail_tgt = (r_state == ST_WAIT_ACK2 && w_rx && i_rx_data == RSP_RESEND)
                       ? ST_SEND_F4 : ST_SEND_FF;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RST;
         r_cnt       <= '0;
         r_retry     <= '0;
         r_sent      <= 1'b0;
         r_wr        <= 1'b0;
         r_tx_data   <= 8'h00;
         r_init_done <= (SKIP_INIT != 0);
         r_err       <= 1'b0;
      end else begin
         r_wr <= 1'b0;
         if (w_is_wait) begin
            if ((w_rx && i_rx_data != w_expect) || (!w_rx && w_timeout)) begin
               r_cnt <= '0;
               if (r_retry == RTY_LAST) begin
                  r_state     <= ST_ERROR;
                  r_err       <= 1'b1;
                  r_init_done <= 1'b0;
               end else begin
                  r_retry <= r_retry + RTY_W'(1);
                  r_state <= w_fail_tgt;
               end
            end else if (w_rx) begin
               r_cnt   <= '0;
               r_state <= w_ok_next;
               if (w_ok_next == ST_STREAM_B0)
                  r_init_done <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            case (r_state)
               ST_SEND_FF, ST_SEND_F4: begin
                  r_cnt <= '0;
                  if (!r_sent) begin
                     if (i_tx_idle) begin
                        r_wr      <= 1'b1;
                        r_sent    <= 1'b1;
                        r_tx_data <= (r_state == ST_SEND_FF) ? CMD_RESET : CMD_ENABLE;
                     end
                  end else if (i_tx_done_tick) begin
                     r_sent  <= 1'b0;
                     r_state <= (r_state == ST_SEND_FF) ? ST_WAIT_ACK : ST_WAIT_ACK2;
                  end
               end
               ST_STREAM_B0: begin
                  r_cnt <= '0;
                  if (w_rx && i_rx_data[3])
                     r_state <= ST_STREAM_B1;
               end
               ST_STREAM_B1, ST_STREAM_B2: begin
                  if (w_rx) begin
                     r_cnt   <= '0;
                     r_state <= (r_state == ST_STREAM_B1) ? ST_STREAM_B2 : ST_APPLY;
                  end else if (w_timeout) begin
                     r_cnt   <= '0;
                     r_state <= ST_STREAM_B0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               ST_APPLY: r_state <= ST_STREAM_B0;
               default:  r_state <= r_state;
            endcase
         end
      end
   end

   // Packet bytes; only meaningful once the matching stream state has accepted them.
   always_ff @(posedge clk) begin
      if (w_rx && r_state == ST_STREAM_B0) r_status <= mouse_status_t'(i_rx_data);
      if (w_rx && r_state == ST_STREAM_B1) r_dx     <= i_rx_data;
      if (w_rx && r_state == ST_STREAM_B2) r_dy     <= i_rx_data;
   end

   mouse_cursor_accum #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
   ) u_accum (
      .clk         (clk),
      .rst         (rst),
      .i_apply     (r_state == ST_APPLY),
      .i_status    (r_status),
      .i_dx        (r_dx),
      .i_dy        (r_dy),
      .o_x         (o_mouse_x),
      .o_y         (o_mouse_y),
      .o_buttons   (o_buttons),
      .o_pkt_valid (o_pkt_valid)
   );

   assign o_wr_ps2    = r_wr;
   assign o_tx_data   = r_tx_data;
   assign o_init_done = r_init_done;
   assign o_err       = r_err;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Scoreboard bench for ps2_mouse_ctrl: init handshake, packet decode, clamp, resync, timeouts, retry.
`timescale 1ns/1ps
module tb_ps2_mouse_ctrl;

   localparam int TO = 100;

   logic       clk = 1'b0, rst = 1'b1;
   logic       rx_done = 1'b0, tx_idle = 1'b1, tx_done = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       wr, pv, idone, err;
   logic [7:0] tx_data;
   logic [9:0] mx, my;
   logic [2:0] btn;

   int checks = 0, errors = 0, cyc = 0, wr_cnt = 0;

   typedef struct { int x; int y; int b; int c; } pkt_t;
   pkt_t       pkt_q[$];
   logic [7:0] tx_q[$];

   ps2_mouse_ctrl #(
      .SCREEN_W(640), .SCREEN_H(480), .TIMEOUT_CYC(TO), .MAX_RETRY(3), .SKIP_INIT(0)
   ) dut (
      .clk(clk), .rst(rst),
      .i_rx_done_tick(rx_done), .i_rx_data(rx_data),
      .i_tx_idle(tx_idle), .i_tx_done_tick(tx_done),
      .o_wr_ps2(wr), .o_tx_data(tx_data),
      .o_mouse_x(mx), .o_mouse_y(my), .o_buttons(btn),
      .o_pkt_valid(pv), .o_init_done(idone), .o_err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Packet monitor: pops the expected cursor state whenever pkt_valid is seen.
   initial begin : pkt_mon
      pkt_t e;
      forever begin
         @(negedge clk);
         if (pv) begin
            if (pkt_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL pkt_unexpected actual x=%0d y=%0d required none", mx, my);
            end else begin
               e = pkt_q.pop_front();
               chk("pkt_x", mx, e.x);
               chk("pkt_y", my, e.y);
               chk("pkt_buttons", btn, e.b);
               chk("pkt_cycle", cyc, e.c);
            end
         end
      end
   end

   // ps2tx stand-in: checks each command byte, then reports it sent 3 cycles later.
   initial begin : tx_phy
      forever begin
         @(negedge clk);
         if (wr) begin
            wr_cnt++;
            if (tx_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL tx_unexpected actual=%h required none", tx_data);
            end else begin
               chk("tx_data", tx_data, tx_q.pop_front());
            end
            repeat (3) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
   endtask

   task automatic rx_idle();
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   // Three-byte packet; stray=1 drives an extra byte in the cycle the DUT sits in APPLY.
   task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input int ex, input int ey, input int eb, input bit stray);
      pkt_t e;
      send_byte(b0); rx_idle();
      send_byte(b1); rx_idle();
      send_byte(b2);
      e = '{ex, ey, eb, cyc + 2};
      pkt_q.push_back(e);
      if (stray) send_byte(8'h08);
      rx_idle();
   endtask

   task automatic wait_wr(input int n);
      int t = 0;
      while (wr_cnt < n && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("wr_count", wr_cnt, n);
   endtask

   initial begin : stim
      int t;
      repeat (3) @(negedge clk);
      chk("rst_x", mx, 320);
      chk("rst_y", my, 240);
      chk("rst_buttons", btn, 0);
      chk("rst_pkt_valid", pv, 0);
      chk("rst_init_done", idone, 0);
      chk("rst_err", err, 0);
      chk("rst_wr", wr, 0);
      chk("rst_tx_data", tx_data, 0);

      // Init handshake
      tx_q.push_back(8'hFF);
      rst = 1'b0;
      wait_wr(1);
      repeat (6) @(negedge clk);
      tx_q.push_back(8'hF4);
      send_byte(8'hFA); rx_idle();
      send_byte(8'hAA); rx_idle();
      send_byte(8'h00); rx_idle();
      wait_wr(2);
      repeat (6) @(negedge clk);
      send_byte(8'hFA); rx_idle();
      chk("init_done", idone, 1);
      chk("init_err", err, 0);

      // Move, then resync + overflow
      pkt(8'h08, 8'h05, 8'h03, 325, 237, 0, 1'b0);
      send_byte(8'h02); rx_idle();
      pkt(8'hC8, 8'hFF, 8'hFF, 325, 237, 0, 1'b0);

      // Partial packet dropped on timeout, then byte during APPLY dropped
      send_byte(8'h08); rx_idle();
      send_byte(8'h05); rx_idle();
      repeat (TO + 20) @(negedge clk);
      pkt(8'h08, 8'h01, 8'h00, 326, 237, 0, 1'b1);
      pkt(8'h08, 8'h02, 8'h00, 328, 237, 0, 1'b0);

      // Clamping at all four edges and button decode
      pkt(8'h38, 8'h00, 8'h00,  72, 479, 0, 1'b0);
      pkt(8'h38, 8'h00, 8'h00,   0, 479, 0, 1'b0);
      pkt(8'h18, 8'h80, 8'h00,   0, 479, 0, 1'b0);
      pkt(8'h08, 8'hFF, 8'h00, 255, 479, 0, 1'b0);
      pkt(8'h08, 8'hFF, 8'h00, 510, 479, 0, 1'b0);
      pkt(8'h08, 8'hFF, 8'h00, 639, 479, 0, 1'b0);
      pkt(8'h08, 8'h00, 8'hFF, 639, 224, 0, 1'b0);
      pkt(8'h08, 8'h00, 8'hFF, 639,   0, 0, 1'b0);
      pkt(8'h09, 8'h00, 8'h00, 639,   0, 1, 1'b0);
      pkt(8'h0F, 8'h00, 8'h00, 639,   0, 7, 1'b0);
      repeat (4) @(negedge clk);
      chk("pkt_queue_drained", pkt_q.size(), 0);

      // Reset mid-packet, then no responses: three FF attempts and ERROR
      send_byte(8'h08); rx_idle();
      send_byte(8'h05); rx_idle();
      repeat (3) tx_q.push_back(8'hFF);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst_x", mx, 320);
      chk("midrst_y", my, 240);
      chk("midrst_buttons", btn, 0);
      chk("midrst_init_done", idone, 0);
      rst = 1'b0;
      wait_wr(5);
      t = 0;
      while (!err && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("retry_err", err, 1);
      chk("retry_init_done", idone, 0);
      repeat (300) @(negedge clk);
      chk("retry_no_more_wr", wr_cnt, 5);
      chk("tx_queue_drained", tx_q.size(), 0);
      chk("err_sticky", err, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
